// File: rtl/noc_pkt_pkg.sv
// Shared flit-format definitions for the NoC traffic generators: field layout,
// flit builder and the generator state encoding.
package noc_pkt_pkg;

  localparam int NODE_W_DEF = 4;

  // Field offsets in units of one node-id field width.
  localparam int DST_LSB  = 1;
  localparam int PASS_LSB = 2;
  localparam int SRC_LSB  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_e;

  // {pad, src, pass, dest, dest}; the caller keeps the low DATA_W bits.
  function automatic logic [63:0] mk_flit(input int unsigned nw,
                                          input logic [15:0] src,
                                          input logic [15:0] pass_idx,
                                          input logic [15:0] dest);
    logic [63:0] m;
    m = (64'd1 << nw) - 64'd1;
    return (({48'd0, src}      & m) << (SRC_LSB  * nw)) |
           (({48'd0, pass_idx} & m) << (PASS_LSB * nw)) |
           (({48'd0, dest}     & m) << (DST_LSB  * nw)) |
            ({48'd0, dest}     & m);
  endfunction

endpackage

// File: rtl/noc_traffic_gen_if.sv
// Valid/ready flit channel from an injection source into a router local port.
interface noc_traffic_gen_if #(
  parameter int DATA_W = 20
);
  logic [DATA_W-1:0] dataout;
  logic              out_valid;
  logic              out_ready;

  modport master (output dataout, output out_valid, input out_ready);
  modport slave  (input dataout, input out_valid, output out_ready);
endinterface

// File: rtl/noc_lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
module noc_lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  logic [15:0] lfsr_q;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= seed;
    end else if (step) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign q = lfsr_q;
endmodule

// File: rtl/noc_traffic_gen.sv
// Per-node all-to-all injection source: walks every destination except itself,
// in ascending or LFSR order, for a number of passes, over a valid/ready port.
module noc_traffic_gen
  import noc_pkt_pkg::*;
#(
  parameter int          NUM_NODES  = 16,
  parameter int          NODE_W     = NODE_W_DEF,
  parameter int          SRC_ID     = 0,
  parameter int          DATA_W     = 20,
  parameter int          NUM_PASSES = 1,
  parameter int          GAP        = 0,
  parameter int          RAND_MODE  = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic                    restart_i,
  noc_traffic_gen_if.master       bus,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [15:0]             sent_count_o
);
  localparam int CW = NODE_W + 1;
  localparam logic [NUM_NODES-1:0] FULL_MASK = ~(NUM_NODES'(1) << SRC_ID);

  state_e              state_q, state_d;
  logic [CW-1:0]       dest_q, dest_d;
  logic [15:0]         pass_q, pass_d;
  logic [15:0]         gap_q, gap_d;
  logic [15:0]         sent_q, sent_d;
  logic [NUM_NODES-1:0] mask_q, mask_d;
  logic [DATA_W-1:0]   flit_q, flit_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;

  logic [15:0]         lfsr_q;
  logic                lfsr_step;
  logic                accept, load;
  logic [CW-1:0]       seq_cand, seq_next, rnd_cand, load_dest;
  logic                seq_wrap, rnd_ok, rnd_end, pass_end, is_last;
  logic [NUM_NODES-1:0] rnd_mask_new;
  logic [63:0]         flit_full;
  logic                unused_bits;

  noc_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst || restart_i),
    .step (lfsr_step),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // Candidate destinations for both orderings; the unused one is pruned by RAND_MODE.
  always_comb begin
    seq_cand = (dest_q == CW'(SRC_ID)) ? dest_q + CW'(1) : dest_q;
    seq_next = seq_cand + CW'(1);
    if (seq_next == CW'(SRC_ID)) seq_next = seq_next + CW'(1);
    seq_wrap = (seq_next >= CW'(NUM_NODES));

    rnd_cand     = {1'b0, lfsr_q[NODE_W-1:0]};
    rnd_mask_new = mask_q | (NUM_NODES'(1) << rnd_cand);
    rnd_ok       = (rnd_cand != CW'(SRC_ID)) && (rnd_cand < CW'(NUM_NODES)) &&
                   ((mask_q & (NUM_NODES'(1) << rnd_cand)) == '0);
    rnd_end      = (rnd_mask_new == FULL_MASK);

    load_dest = (RAND_MODE != 0) ? rnd_cand : seq_cand;
    pass_end  = (RAND_MODE != 0) ? rnd_end  : seq_wrap;
    is_last   = pass_end && (NUM_PASSES != 0) && (pass_q == 16'(NUM_PASSES - 1));
    flit_full = mk_flit(NODE_W, 16'(SRC_ID), pass_q, 16'(load_dest));
  end

  assign accept = valid_q && bus.out_ready;

  // NOTE: every variable gets a default first so no path through the block infers a latch.
  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    pass_d    = pass_q;
    gap_d     = gap_q;
    sent_d    = sent_q;
    mask_d    = mask_q;
    flit_d    = flit_q;
    valid_d   = valid_q;
    last_d    = last_q;
    load      = 1'b0;
    lfsr_step = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_SEND;
          load    = (RAND_MODE == 0);
        end
      end
      ST_SEND: begin
        if (valid_q) begin
          // A pending flit is held until accepted; pause and gap start only afterwards.
          if (accept) begin
            sent_d  = sent_q + 16'd1;
            valid_d = 1'b0;
            if (last_q) begin
              state_d = ST_DONE;
            end else if (GAP > 0) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end else if (!enable_i) begin
              state_d = ST_IDLE;
            end else begin
              load = (RAND_MODE == 0);
            end
          end
        end else if (!enable_i) begin
          state_d = ST_IDLE;
        end else begin
          lfsr_step = 1'b1;
          load      = (RAND_MODE != 0) ? rnd_ok : 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == 16'(GAP - 1)) begin
          state_d = enable_i ? ST_SEND : ST_IDLE;
          load    = enable_i && (RAND_MODE == 0);
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      flit_d  = flit_full[DATA_W-1:0];
      valid_d = 1'b1;
      last_d  = is_last;
      pass_d  = pass_end ? pass_q + 16'd1 : pass_q;
      dest_d  = pass_end ? '0 : seq_next;
      mask_d  = pass_end ? '0 : rnd_mask_new;
    end

    // Restart aborts even a flit mid-handshake.
    if (restart_i) begin
      state_d = ST_IDLE;
      dest_d  = '0;
      pass_d  = '0;
      gap_d   = '0;
      sent_d  = '0;
      mask_d  = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // NOTE: the sent mask is plain state, so it is reset like every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      pass_q  <= '0;
      gap_q   <= '0;
      sent_q  <= '0;
      mask_q  <= '0;
      flit_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      pass_q  <= pass_d;
      gap_q   <= gap_d;
      sent_q  <= sent_d;
      mask_q  <= mask_d;
      flit_q  <= flit_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.dataout   = flit_q;
  assign bus.out_valid = valid_q;
  assign busy_o        = (state_q == ST_SEND) || (state_q == ST_GAP);
  assign done_o        = (state_q == ST_DONE);
  assign sent_count_o  = sent_q;

  assign unused_bits = ^{lfsr_q[15:NODE_W], flit_full[63:DATA_W]};
endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed bench: sequential (A: src 6), gap + two passes (B: src 0),
// LFSR order (C: src 3) instances of noc_traffic_gen.
module tb_noc_traffic_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_en, a_rs, b_en, b_rs, c_en, c_rs;
  logic        a_busy, a_done, b_busy, b_done, c_busy, c_done;
  logic [15:0] a_cnt, b_cnt, c_cnt;

  noc_traffic_gen_if #(.DATA_W(20)) a_if ();
  noc_traffic_gen_if #(.DATA_W(20)) b_if ();
  noc_traffic_gen_if #(.DATA_W(20)) c_if ();

  noc_traffic_gen #(.SRC_ID(6)) u_a (
    .clk(clk), .rst(rst), .enable_i(a_en), .restart_i(a_rs), .bus(a_if.master),
    .busy_o(a_busy), .done_o(a_done), .sent_count_o(a_cnt));
  noc_traffic_gen #(.SRC_ID(0), .NUM_PASSES(2), .GAP(2)) u_b (
    .clk(clk), .rst(rst), .enable_i(b_en), .restart_i(b_rs), .bus(b_if.master),
    .busy_o(b_busy), .done_o(b_done), .sent_count_o(b_cnt));
  noc_traffic_gen #(.SRC_ID(3), .RAND_MODE(1)) u_c (
    .clk(clk), .rst(rst), .enable_i(c_en), .restart_i(c_rs), .bus(c_if.master),
    .busy_o(c_busy), .done_o(c_done), .sent_count_o(c_cnt));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [19:0] qa[$], qb[$], qc[$];
  int          ta[$], tb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake inputs are stable from posedge+1 to the next posedge, so a
  // negedge sample with valid && ready is exactly an accept on the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_if.out_valid && a_if.out_ready && !a_rs) begin
        qa.push_back(a_if.dataout); ta.push_back(cyc);
      end
      if (b_if.out_valid && b_if.out_ready && !b_rs) begin
        qb.push_back(b_if.dataout); tb.push_back(cyc);
      end
      if (c_if.out_valid && c_if.out_ready && !c_rs) qc.push_back(c_if.dataout);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ascending order for src 6: k-th flit goes to dest k, skipping 6.
  function automatic logic [19:0] exp_a(input int k);
    logic [3:0] d;
    d = 4'((k < 6) ? k : k + 1);
    return {8'h06, 4'h0, d, d};
  endfunction

  task automatic check_seq_a(input string tag);
    check({tag, "_len"}, qa.size(), 15);
    for (int k = 0; k < qa.size() && k < 15; k++)
      check($sformatf("%s_flit%0d", tag, k), qa[k], exp_a(k));
  endtask

  task automatic wait_done(input int which, input int budget, input string tag);
    logic dn;
    dn = 1'b0;
    for (int i = 0; i < budget && !dn; i++) begin
      tick();
      dn = (which == 0) ? a_done : (which == 1) ? b_done : c_done;
    end
    check({tag, "_done"}, dn, 1'b1);
  endtask

  task automatic wait_flit_a(input logic [19:0] v, input string tag);
    logic seen;
    seen = a_if.out_valid && (a_if.dataout == v);
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      seen = a_if.out_valid && (a_if.dataout == v);
    end
    check({tag, "_seen"}, seen, 1'b1);
  endtask

  task automatic restart_a();
    a_rs = 1'b1;
    tick();
    a_rs = 1'b0;
  endtask

  initial begin
    int          bad_gap, hits3;
    logic [15:0] l, seen_mask;
    logic [3:0]  c4;
    logic [19:0] mq[$];
    logic        held;

    rst = 1'b1;
    {a_en, a_rs, b_en, b_rs, c_en, c_rs} = '0;
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;
    c_if.out_ready = 1'b1;
    repeat (3) tick();

    check("rst_valid", a_if.out_valid, 1'b0);
    check("rst_data", a_if.dataout, 20'h0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_done", a_done, 1'b0);
    check("rst_cnt", a_cnt, 16'd0);
    check("rst_c_data", c_if.dataout, 20'h0);

    rst  = 1'b0;
    a_en = 1'b1;
    b_en = 1'b1;
    c_en = 1'b1;

    // Basic stream with one cycle of latency from IDLE.
    tick();
    check("t1_lat_valid", a_if.out_valid, 1'b1);
    check("t1_lat_data", a_if.dataout, 20'h06000);
    wait_done(0, 100, "t1");
    check_seq_a("t1");
    if (ta.size() == 15) check("t1_span", ta[14] - ta[0], 14);
    check("t1_cnt", a_cnt, 16'd15);
    check("t1_valid", a_if.out_valid, 1'b0);
    check("t1_busy", a_busy, 1'b0);
    repeat (3) tick();
    check("t1_done_sticky", a_done, 1'b1);
    check("t1_no_extra", qa.size(), 15);

    // Restart out of DONE.
    a_en = 1'b0;
    restart_a();
    check("t6d_done", a_done, 1'b0);
    check("t6d_cnt", a_cnt, 16'd0);
    check("t6d_valid", a_if.out_valid, 1'b0);

    // Backpressure on the 06033 flit.
    qa.delete(); ta.delete();
    a_en = 1'b1;
    wait_flit_a(20'h06033, "t2");
    a_if.out_ready = 1'b0;
    held = 1'b1;
    repeat (5) begin
      tick();
      held = held && a_if.out_valid && (a_if.dataout == 20'h06033);
    end
    check("t2_hold", held, 1'b1);
    a_if.out_ready = 1'b1;
    wait_done(0, 100, "t2");
    check_seq_a("t2");
    check("t2_cnt", a_cnt, 16'd15);

    // Pause while the 06044 flit is stalled.
    a_en = 1'b0;
    restart_a();
    qa.delete(); ta.delete();
    a_en = 1'b1;
    wait_flit_a(20'h06044, "t5");
    a_if.out_ready = 1'b0;
    a_en = 1'b0;
    repeat (3) tick();
    check("t5_hold", {a_if.out_valid, a_if.dataout}, {1'b1, 20'h06044});
    a_if.out_ready = 1'b1;
    tick();
    check("t5_idle_valid", a_if.out_valid, 1'b0);
    check("t5_idle_busy", a_busy, 1'b0);
    check("t5_cnt", a_cnt, 16'd5);
    repeat (3) tick();
    check("t5_paused", qa.size(), 5);
    a_en = 1'b1;
    wait_done(0, 100, "t5");
    check_seq_a("t5");

    // Restart mid-pass while a flit is being accepted.
    a_en = 1'b0;
    restart_a();
    qa.delete(); ta.delete();
    a_en = 1'b1;
    for (int i = 0; i < 100 && a_cnt != 16'd7; i++) tick();
    check("t6_reach7", a_cnt, 16'd7);
    a_rs = 1'b1;
    tick();
    a_rs = 1'b0;
    check("t6_valid", a_if.out_valid, 1'b0);
    check("t6_cnt", a_cnt, 16'd0);
    check("t6_done", a_done, 1'b0);
    qa.delete(); ta.delete();
    wait_done(0, 100, "t6");
    check_seq_a("t6");

    // Two passes with a 2-cycle gap; src 0 and pass index sit in bits [15:12] and [11:8].
    wait_done(1, 400, "t3");
    check("t3_len", qb.size(), 30);
    for (int k = 0; k < qb.size() && k < 30; k++) begin
      logic [3:0] d, p;
      d = 4'(k % 15 + 1);
      p = 4'(k / 15);
      check($sformatf("t3_flit%0d", k), qb[k], {8'h00, p, d, d});
    end
    bad_gap = 0;
    for (int k = 1; k < tb.size(); k++) if (tb[k] - tb[k-1] != 3) bad_gap++;
    check("t3_gap", bad_gap, 0);
    check("t3_cnt", b_cnt, 16'd30);

    // LFSR order against a reference LFSR walk from the seed.
    l = 16'hACE1;
    seen_mask = '0;
    for (int i = 0; i < 10000 && mq.size() < 15; i++) begin
      c4 = l[3:0];
      if (c4 != 4'd3 && !seen_mask[c4]) begin
        seen_mask[c4] = 1'b1;
        mq.push_back({8'h03, 4'h0, c4, c4});
      end
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    wait_done(2, 3000, "t4");
    check("t4_len", qc.size(), 15);
    for (int k = 0; k < qc.size() && k < mq.size(); k++)
      check($sformatf("t4_flit%0d", k), qc[k], mq[k]);
    hits3 = 0;
    seen_mask = '0;
    foreach (qc[k]) begin
      if (qc[k][7:4] == 4'd3) hits3++;
      seen_mask[qc[k][7:4]] = 1'b1;
    end
    check("t4_no_src", hits3, 0);
    check("t4_distinct", $countones(seen_mask), 15);
    check("t4_cnt", c_cnt, 16'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
